// File: rtl/cluster_event_cdc_rx.sv
// Cluster-side reader of the asynchronous event FIFO: synchronises the gray write
// pointer, pops entries into a single output register and returns the gray read pointer.
module cluster_event_cdc_rx #(
  parameter int unsigned EVNT_WIDTH          = 8,
  parameter int unsigned CDC_FIFOS_LOG_DEPTH = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic [CDC_FIFOS_LOG_DEPTH:0]                         async_cluster_events_wptr_i,
  output logic [CDC_FIFOS_LOG_DEPTH:0]                         async_cluster_events_rptr_o,
  input  logic [EVNT_WIDTH-1:0][(2**CDC_FIFOS_LOG_DEPTH)-1:0]  async_cluster_events_data_i,
  output logic                                                 evt_valid_o,
  output logic [EVNT_WIDTH-1:0]                                evt_data_o,
  input  logic                                                 evt_ready_i,
  output logic [CDC_FIFOS_LOG_DEPTH:0]                         fill_level_o,
  output logic                                                 overflow_o
);

  localparam int unsigned DEPTH = 2**CDC_FIFOS_LOG_DEPTH;
  localparam int unsigned PW    = CDC_FIFOS_LOG_DEPTH + 1;
  localparam int unsigned IW    = CDC_FIFOS_LOG_DEPTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         wptr_s;
  logic [PW-1:0]         wbin;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         fill_q, fill_d;
  logic [PW-1:0]         pending;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic [EVNT_WIDTH-1:0] data_q, data_d;
  logic [EVNT_WIDTH-1:0] rd_data;
  logic [IW-1:0]         rd_idx;
  logic                  empty;
  logic                  pop;

  // Write pointer synchroniser chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= async_cluster_events_wptr_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wptr_s = sync_q[SYNC_STAGES-1];

  // rptr_q always equals gray(rbin_q), so empty needs no extra conversion
  always_comb begin
    wbin    = gray2bin(wptr_s);
    empty   = (wptr_s == rptr_q);
    pop     = !empty && (!valid_q || evt_ready_i);
    rd_idx  = rbin_q[IW-1:0];
    rd_data = '0;
    for (int unsigned i = 0; i < EVNT_WIDTH; i++) begin
      rd_data[i] = async_cluster_events_data_i[i][rd_idx];
    end
    rbin_d  = pop ? rbin_q + PW'(1) : rbin_q;
    pending = wbin - rbin_q;
    fill_d  = wbin - rbin_d;
    ovf_d   = ovf_q | (pending > PW'(DEPTH));
    valid_d = valid_q;
    data_d  = data_q;
    if (pop) begin
      valid_d = 1'b1;
      data_d  = rd_data;
    end else if (valid_q && evt_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= bin2gray(rbin_d);
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign async_cluster_events_rptr_o = rptr_q;
  assign fill_level_o                = fill_q;
  assign overflow_o                  = ovf_q;
  assign evt_valid_o                 = valid_q;
  assign evt_data_o                  = data_q;

endmodule

// File: tb/tb_cluster_event_cdc_rx.sv
// Directed bench for cluster_event_cdc_rx with default parameters (8-bit events, depth 8).
module tb_cluster_event_cdc_rx;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [3:0]      wptr;
  logic [3:0]      rptr;
  logic [7:0][7:0] fifo_mem;
  logic            evt_valid;
  logic [7:0]      evt_data;
  logic            evt_ready;
  logic [3:0]      fill_level;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  cluster_event_cdc_rx dut (
    .clk_i                       (clk),
    .rst_i                       (rst_i),
    .async_cluster_events_wptr_i (wptr),
    .async_cluster_events_rptr_o (rptr),
    .async_cluster_events_data_i (fifo_mem),
    .evt_valid_o                 (evt_valid),
    .evt_data_o                  (evt_data),
    .evt_ready_i                 (evt_ready),
    .fill_level_o                (fill_level),
    .overflow_o                  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int unsigned b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic write_entry(input int k, input logic [7:0] v);
    for (int i = 0; i < 8; i++) fifo_mem[i][k] = v[i];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},    32'(evt_valid),  0);
    check({tag, "_data"},     32'(evt_data),   0);
    check({tag, "_rptr"},     32'(rptr),       0);
    check({tag, "_fill"},     32'(fill_level), 0);
    check({tag, "_overflow"}, 32'(overflow),   0);
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    wptr      = 4'd0;
    evt_ready = 1'b0;
    #2;
    check_zero("rst");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // Collect n events with ready held high; every valid cycle is one transfer
  task automatic expect_events(input int n, input int first);
    int         got = 0;
    int         cyc = 0;
    logic [3:0] prev;
    prev = gray4(32'(first));
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (evt_valid) begin
        check("wrap_data", 32'(evt_data), 32'(8'h40 + first + got));
        check("wrap_rptr", 32'(rptr), 32'(gray4(32'(first + got + 1))));
        check("wrap_gray_step", 32'($countones(rptr ^ prev)), 1);
        prev = rptr;
        got++;
      end
    end
    if (got != n) check("wrap_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i     = 1'b0;
    wptr      = 4'd0;
    evt_ready = 1'b0;
    fifo_mem  = '0;
    #1;
    do_reset();

    // Single event: valid three edges after the wptr change
    write_entry(0, 8'hA5);
    wptr = 4'b0001;
    step(2);
    check("single_early_valid", 32'(evt_valid), 0);
    step(1);
    check("single_valid", 32'(evt_valid), 1);
    check("single_data", 32'(evt_data), 32'h A5);
    check("single_rptr", 32'(rptr), 32'h1);
    evt_ready = 1'b1;
    step(1);
    check("single_drain_valid", 32'(evt_valid), 0);
    check("single_drain_data", 32'(evt_data), 32'hA5);
    check("single_drain_rptr", 32'(rptr), 32'h1);
    check("single_fill", 32'(fill_level), 0);

    // Full-depth burst with ready held high
    do_reset();
    for (int k = 0; k < 8; k++) write_entry(k, 8'(8'h10 + k));
    evt_ready = 1'b1;
    wptr = 4'b1100;
    step(3);
    for (int i = 0; i < 8; i++) begin
      check("burst_valid", 32'(evt_valid), 1);
      check("burst_data", 32'(evt_data), 32'(8'h10 + i));
      step(1);
    end
    check("burst_end_valid", 32'(evt_valid), 0);
    check("burst_rptr", 32'(rptr), 32'b1100);
    check("burst_fill", 32'(fill_level), 0);
    check("burst_overflow", 32'(overflow), 0);

    // Backpressure: head held stable, remaining three counted as pending
    do_reset();
    for (int k = 0; k < 4; k++) write_entry(k, 8'(k + 1));
    wptr = 4'b0110;
    step(3);
    check("bp_valid", 32'(evt_valid), 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_hold_data", 32'(evt_data), 32'h1);
    end
    check("bp_hold_valid", 32'(evt_valid), 1);
    check("bp_fill", 32'(fill_level), 3);
    evt_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step(1);
      check("bp_release_valid", 32'(evt_valid), 1);
      check("bp_release_data", 32'(evt_data), 32'(i));
    end
    step(1);
    check("bp_end_valid", 32'(evt_valid), 0);
    check("bp_end_fill", 32'(fill_level), 0);

    // Wrap-around: 20 events in batches of 4, pointers pass 15 -> 0
    do_reset();
    evt_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) write_entry((b * 4 + j) % 8, 8'(8'h40 + b * 4 + j));
      wptr = gray4(32'(b * 4 + 4));
      expect_events(4, b * 4);
    end
    step(2);
    check("wrap_rptr_final", 32'(rptr), 32'b0110);
    check("wrap_overflow", 32'(overflow), 0);

    // Overflow: writer jumps 10 entries ahead of an empty reader
    do_reset();
    wptr = 4'b1111;
    step(2);
    check("ovf_before", 32'(overflow), 0);
    step(1);
    check("ovf_set", 32'(overflow), 1);
    evt_ready = 1'b1;
    step(20);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_drained_rptr", 32'(rptr), 32'b1111);

    // Reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 8; k++) write_entry(k, 8'(8'h20 + k));
    evt_ready = 1'b1;
    wptr = 4'b1100;
    step(3);
    check("mid_data0", 32'(evt_data), 32'h20);
    step(1);
    check("mid_data1", 32'(evt_data), 32'h21);
    step(1);
    check("mid_data2", 32'(evt_data), 32'h22);
    #2;
    rst_i = 1'b1;
    wptr  = 4'd0;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    rst_i = 1'b0;
    step(10);
    check("mid_post_valid", 32'(evt_valid), 0);
    check("mid_post_fill", 32'(fill_level), 0);
    check("mid_post_rptr", 32'(rptr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cluster_event_cdc_rx.md
# cluster_event_cdc_rx

Receiving end of the asynchronous cluster event bus driven from the SoC domain. It synchronises the gray-coded write pointer and pops event words from the shared async FIFO storage. Each event is presented as a valid/ready stream in the cluster clock domain, and the gray-coded read pointer is returned to the SoC-side writer. It sits inside the cluster domain, directly on the `async_cluster_events_*` wires.

## Interface
Reset is asynchronous and active-high; the block uses one clock.

Parameters:
- `EVNT_WIDTH`, default 8: width of one event word.
- `CDC_FIFOS_LOG_DEPTH`, default 3: log2 of the FIFO depth, so DEPTH = 2**CDC_FIFOS_LOG_DEPTH.
- `SYNC_STAGES`, default 2: number of flops in the wptr synchroniser; must be >= 2.

Ports:
- `clk_i` input, 1: cluster-domain clock.
- `rst_i` input, 1: asynchronous, active-high reset.
- `async_cluster_events_wptr_i` input, LOG_DEPTH+1: gray write pointer from the SoC domain.
- `async_cluster_events_rptr_o` output, LOG_DEPTH+1: gray read pointer returned to the writer; registered.
- `async_cluster_events_data_i` input, [EVNT_WIDTH-1:0][DEPTH-1:0]: FIFO storage. Entry k is {data[EVNT_WIDTH-1][k], …, data[0][k]}.
- `evt_valid_o` output, 1: an event is available.
- `evt_data_o` output, EVNT_WIDTH: event word.
- `evt_ready_i` input, 1: the consumer accepts the event.
- `fill_level_o` output, LOG_DEPTH+1: number of entries pending in the FIFO, excluding the output register.
- `overflow_o` output, 1: sticky protocol error.

## Operation
- **Synchroniser.** `wptr_i` passes through SYNC_STAGES flops to give wptr_s (gray). wptr_s is converted to binary wbin.
- **Read pointer.** The block keeps a binary read pointer rbin of LOG_DEPTH+1 bits.
  - `rptr_o` = gray(rbin), registered and updated in the same edge as rbin.
  - Gray code is g = b ^ (b>>1).
- **Empty.** The FIFO is empty when wptr_s == gray(rbin).
- **Fill level.** `fill_level_o` = (wbin − rbin) mod 2**(LOG_DEPTH+1), registered.
- **Output register.** A single-entry register holds `evt_valid_o` and `evt_data_o`.
- **Pop.** pop = !empty && (!evt_valid_o || evt_ready_i).
  - On pop, the register loads entry rbin[LOG_DEPTH-1:0], `evt_valid_o` is set to 1 and rbin increments.
  - rbin wraps naturally at 2**(LOG_DEPTH+1).
- **Drain.** When evt_ready_i && evt_valid_o && empty, `evt_valid_o` goes to 0. `evt_data_o` holds its last value.
- **Stall.** When evt_valid_o && !evt_ready_i, `evt_data_o` and `evt_valid_o` hold and no pop occurs.
- **Overflow.** `overflow_o` is set when (wbin − rbin) > DEPTH, i.e. the writer advanced beyond capacity. It is cleared only by reset, and does not block operation.
- **Storage reads.** The writer guarantees that an entry is stable before it advances wptr. Storage is read combinationally only at the pop index.
- **Fixed choices.** No flush, no fall-through path, no bypass.

## Timing
- **Reset values.**
  - `rptr_o` = 0, `evt_valid_o` = 0, `evt_data_o` = 0, `fill_level_o` = 0, `overflow_o` = 0.
  - All synchroniser flops reset to 0.
- **Write-to-valid latency.** A wptr change at edge N becomes wptr_s after SYNC_STAGES edges. The pop happens on the next edge, and `evt_valid_o` is high after SYNC_STAGES+1 edges (3 cycles with defaults).
- **Pointer update.** `rptr_o` updates in the same edge as the pop, so the writer sees the freed slot after its own synchroniser delay.
- **Throughput.** With `evt_ready_i` held at 1 and a non-empty FIFO, one event is delivered per cycle with back-to-back pops.
- **Handshake rules.**
  - A transfer occurs on the edge where valid && ready.
  - `evt_valid_o` never drops without a transfer.
  - `evt_data_o` never changes while valid && !ready.
- **Full FIFO.** Full (fill = DEPTH) is legal: all DEPTH entries are drained in order, and pointer wrap is seamless.
- **Reset mid-operation.** The block returns to reset values immediately (async). Any pending output event is lost, and `rptr_o` = 0. The writer must be reset in the same window.
- **Simultaneous events.** A transfer and a pop in the same edge load the new entry with valid kept at 1.

## Test plan
- **Single event.** After reset, write entry 0 = 0xA5 and set wptr gray 0001. Expect `evt_valid_o`=1 and `evt_data_o`=0xA5 three cycles later. With ready=1, expect valid=0 on the next cycle and `rptr_o`=0001.
- **Burst with ready held high.** Write 8 entries 0x10..0x17 and set wptr = gray(8) = 1100. Expect 8 consecutive valid cycles delivering 0x10..0x17. Then expect `rptr_o`=1100 and `fill_level_o`=0.
- **Backpressure.** Fill 4 entries (0x01..0x04) and hold ready=0 for 10 cycles. Expect `evt_data_o`=0x01 stable and `fill_level_o`=3. Then release ready and expect 0x01..0x04 in order.
- **Wrap-around.** Run 20 events through with pointers wrapping past 15 to 0. Expect data order preserved, gray `rptr_o` changing by one bit per pop, and no `overflow_o`.
- **Overflow.** Jump wptr to gray(10) with rbin=0. Expect `overflow_o`=1 after sync and that it stays 1 until `rst_i`.
- **Reset mid-burst.** Assert `rst_i` for 1 cycle after 3 of 8 events. Expect all outputs 0 immediately. After reset, with the writer also reset and wptr=0, the FIFO stays empty.
